// File: rtl/pipeline_restoring_divider_if.sv
// Operand/result bundle for the pipelined signed 16/8 divider.
`timescale 1ns/1ps
interface pipeline_restoring_divider_if;
    logic        in_valid;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    modport master (
        output in_valid, dividend, divisor,
        input  out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor,
        output out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/pipeline_restoring_divider.sv
// Fully pipelined signed 16/8 restoring divider: one operation per clock,
// sign-magnitude front end, 2 quotient bits per stage, saturating sign fix.
`timescale 1ns/1ps
module pipeline_restoring_divider (
    input  logic                               clk,
    input  logic                               rst_n,
    pipeline_restoring_divider_if.slave        io_div
);

    localparam int unsigned DVD_W      = 16;
    localparam int unsigned DVS_W      = 8;
    localparam int unsigned REM_W      = DVS_W + 1;
    localparam int unsigned N_STG      = 8;
    localparam int unsigned IT_PER_STG = 2;

    // Index 0 is the input register; index N_STG holds the finished unsigned result.
    logic [N_STG:0]                 r_vld;
    logic [N_STG:0]                 r_dsgn;
    logic [N_STG:0]                 r_qsgn;
    logic [N_STG:0]                 r_dz;
    logic [N_STG:0][REM_W-1:0]      r_rem;
    logic [N_STG:0][DVD_W-1:0]      r_dq;
    logic [N_STG:0][DVS_W-1:0]      r_dvs;

    logic [N_STG-1:0][REM_W-1:0]    w_rem;
    logic [N_STG-1:0][DVD_W-1:0]    w_dq;

    logic [DVD_W-1:0]               w_dvd_mag;
    logic [DVS_W-1:0]               w_dvs_mag;

    logic [DVD_W-1:0]               w_qu;
    logic [REM_W-1:0]               w_ru;
    logic [REM_W-1:0]               w_ru_neg;
    logic                           w_ovf;
    logic [DVS_W-1:0]               w_fx_q;
    logic [DVS_W-1:0]               w_fx_r;
    logic                           w_fx_dz;
    logic                           w_fx_ov;

    logic                           r_fx_vld;
    logic [DVS_W-1:0]               r_fx_q;
    logic [DVS_W-1:0]               r_fx_r;
    logic                           r_fx_dz;
    logic                           r_fx_ov;

    logic                           r_o_vld;
    logic [DVS_W-1:0]               r_o_q;
    logic [DVS_W-1:0]               r_o_r;
    logic                           r_o_dz;
    logic                           r_o_ov;

    // One pipeline stage: IT_PER_STG shift / trial-subtract / restore steps.
    // The dividend register doubles as the quotient register, quotient bits enter at the LSB.
    function automatic logic [REM_W+DVD_W-1:0] div_stage(
        input logic [REM_W-1:0] rem_in,
        input logic [DVD_W-1:0] dq_in,
        input logic [DVS_W-1:0] dvs
    );
        logic [REM_W-1:0] rem;
        logic [DVD_W-1:0] dq;
        logic [REM_W-1:0] sh;
        logic [REM_W:0]   diff;
        logic             qb;
        rem = rem_in;
        dq  = dq_in;
        for (int unsigned j = 0; j < IT_PER_STG; j++) begin
            sh   = REM_W'({rem, dq[DVD_W-1]});
            diff = {1'b0, sh} - {2'b00, dvs};
            qb   = ~diff[REM_W];
            rem  = qb ? diff[REM_W-1:0] : sh;
            dq   = {dq[DVD_W-2:0], qb};
        end
        return {rem, dq};
    endfunction

    // Operand magnitudes; -32768 and -128 map onto 0x8000 and 0x80.
    always_comb begin
        w_dvd_mag = io_div.dividend;
        w_dvs_mag = io_div.divisor;
        if (io_div.dividend[DVD_W-1]) begin
            w_dvd_mag = DVD_W'(~io_div.dividend + DVD_W'(1));
        end
        if (io_div.divisor[DVS_W-1]) begin
            w_dvs_mag = DVS_W'(~io_div.divisor + DVS_W'(1));
        end
    end

    always_comb begin
        w_rem = '0;
        w_dq  = '0;
        for (int unsigned k = 0; k < N_STG; k++) begin
            {w_rem[k], w_dq[k]} = div_stage(r_rem[k], r_dq[k], r_dvs[k]);
        end
    end

    // Input register and the eight division stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_dsgn <= '0;
            r_qsgn <= '0;
            r_dz   <= '0;
            r_rem  <= '0;
            r_dq   <= '0;
            r_dvs  <= '0;
        end else begin
            r_vld[0]  <= io_div.in_valid;
            r_dsgn[0] <= io_div.dividend[DVD_W-1];
            r_qsgn[0] <= io_div.dividend[DVD_W-1] ^ io_div.divisor[DVS_W-1];
            r_dz[0]   <= (io_div.divisor == '0);
            r_rem[0]  <= '0;
            r_dq[0]   <= w_dvd_mag;
            r_dvs[0]  <= w_dvs_mag;
            for (int unsigned k = 0; k < N_STG; k++) begin
                r_vld[k+1]  <= r_vld[k];
                r_dsgn[k+1] <= r_dsgn[k];
                r_qsgn[k+1] <= r_qsgn[k];
                r_dz[k+1]   <= r_dz[k];
                r_rem[k+1]  <= w_rem[k];
                r_dq[k+1]   <= w_dq[k];
                r_dvs[k+1]  <= r_dvs[k];
            end
        end
    end

    // Sign fix, saturation and divide-by-zero override; flags only live with a valid result.
    always_comb begin
        w_qu     = r_dq[N_STG];
        w_ru     = r_rem[N_STG];
        w_ru_neg = REM_W'(~w_ru + REM_W'(1));
        w_ovf    = r_qsgn[N_STG] ? (w_qu > DVD_W'(128)) : (w_qu > DVD_W'(127));
        w_fx_q   = r_qsgn[N_STG] ? DVS_W'(~w_qu[DVS_W-1:0] + DVS_W'(1)) : w_qu[DVS_W-1:0];
        w_fx_r   = DVS_W'(r_dsgn[N_STG] ? w_ru_neg : w_ru);
        w_fx_dz  = r_vld[N_STG] & r_dz[N_STG];
        w_fx_ov  = r_vld[N_STG] & ~r_dz[N_STG] & w_ovf;
        if (r_dz[N_STG]) begin
            w_fx_q = '0;
            w_fx_r = '0;
        end else if (w_ovf) begin
            w_fx_q = r_qsgn[N_STG] ? 8'h80 : 8'h7F;
        end
    end

    // Sign-fix register followed by the output register, giving the 10-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fx_vld <= 1'b0;
            r_fx_q   <= '0;
            r_fx_r   <= '0;
            r_fx_dz  <= 1'b0;
            r_fx_ov  <= 1'b0;
            r_o_vld  <= 1'b0;
            r_o_q    <= '0;
            r_o_r    <= '0;
            r_o_dz   <= 1'b0;
            r_o_ov   <= 1'b0;
        end else begin
            r_fx_vld <= r_vld[N_STG];
            r_fx_q   <= w_fx_q;
            r_fx_r   <= w_fx_r;
            r_fx_dz  <= w_fx_dz;
            r_fx_ov  <= w_fx_ov;
            r_o_vld  <= r_fx_vld;
            r_o_q    <= r_fx_q;
            r_o_r    <= r_fx_r;
            r_o_dz   <= r_fx_dz;
            r_o_ov   <= r_fx_ov;
        end
    end

    assign io_div.out_valid = r_o_vld;
    assign io_div.quotient  = r_o_q;
    assign io_div.remainder = r_o_r;
    assign io_div.div_zero  = r_o_dz;
    assign io_div.overflow  = r_o_ov;

endmodule

// File: tb/tb_pipeline_restoring_divider.sv
// Bench for pipeline_restoring_divider: directed vector table, random traffic
// against an integer-arithmetic reference, and reset corner sequences.
`timescale 1ns/1ps
module tb_pipeline_restoring_divider;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         issue;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    vec_t tbl[12];

    pipeline_restoring_divider_if dif();

    pipeline_restoring_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_div (dif)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        int   qt;
        int   rt;
        sa = int'($signed(a));
        sbv = int'($signed(b));
        e.issue = 0;
        if (sbv == 0) begin
            e.q = 8'h00; e.r = 8'h00; e.dz = 1'b1; e.ov = 1'b0;
        end else begin
            qt = sa / sbv;
            rt = sa % sbv;
            e.dz = 1'b0;
            e.ov = (qt > 127) || (qt < -128);
            if (qt > 127)       e.q = 8'h7F;
            else if (qt < -128) e.q = 8'h80;
            else                e.q = 8'(qt);
            e.r = 8'(rt);
        end
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [7:0] b, input exp_t e);
        exp_t t;
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        t = e;
        t.issue = cyc + 1;
        sb.push_back(t);
    endtask

    task automatic drive_vec(input vec_t v);
        exp_t e;
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.ov = v.ov; e.issue = 0;
        drive(v.dvd, v.dvs, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dif.in_valid = 1'b0;
            dif.dividend = 16'($urandom);
            dif.divisor  = 8'($urandom);
        end
    endtask

    task automatic drive_rand();
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  qq;
        b  = 8'($urandom);
        if ($urandom_range(15) == 0) b = 8'h00;
        qq = 8'($urandom);
        case ($urandom_range(2))
            0:       a = 16'($urandom);
            1:       a = 16'(int'($signed(b)) * int'($signed(qq)));
            default: a = 16'(int'($signed(b)) * int'($signed(qq)) + int'($urandom_range(7)) - 3);
        endcase
        drive(a, b, model(a, b));
    endtask

    // Per-cycle monitor: out_valid must match the scoreboard head's 10-edge due time.
    always @(posedge clk) begin
        logic exp_v;
        exp_t e;
        #1;
        if (rst_n) begin
            exp_v = (sb.size() != 0) && (sb[0].issue + 10 == cyc);
            chk("out_valid", 32'(dif.out_valid), 32'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                if (dif.out_valid) begin
                    chk("quotient",  32'(dif.quotient),  32'(e.q));
                    chk("remainder", 32'(dif.remainder), 32'(e.r));
                    chk("div_zero",  32'(dif.div_zero),  32'(e.dz));
                    chk("overflow",  32'(dif.overflow),  32'(e.ov));
                end
            end else begin
                chk("div_zero_idle", 32'(dif.div_zero), 32'd0);
                chk("overflow_idle", 32'(dif.overflow), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        dif.in_valid = 1'b0;
        dif.dividend = 16'h0000;
        dif.divisor  = 8'h00;

        tbl[0]  = '{16'h0014, 8'h04, 8'h05, 8'h00, 1'b0, 1'b0};  // 20/4
        tbl[1]  = '{16'hFFC1, 8'h07, 8'hF7, 8'h00, 1'b0, 1'b0};  // -63/7
        tbl[2]  = '{16'h0017, 8'hFB, 8'hFC, 8'h03, 1'b0, 1'b0};  // 23/-5
        tbl[3]  = '{16'hFFE9, 8'h05, 8'hFC, 8'hFD, 1'b0, 1'b0};  // -23/5
        tbl[4]  = '{16'hFFE9, 8'hFB, 8'h04, 8'hFD, 1'b0, 1'b0};  // -23/-5
        tbl[5]  = '{16'h04D2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};  // 1234/0
        tbl[6]  = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0};  // 100/10
        tbl[7]  = '{16'h03E8, 8'h02, 8'h7F, 8'h00, 1'b0, 1'b1};  // 1000/2
        tbl[8]  = '{16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b1};  // -32768/-1
        tbl[9]  = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};  // -128/1
        tbl[10] = '{16'h8000, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b1};  // -32768/-128
        tbl[11] = '{16'h007F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};  // 127/-128

        #100;
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_quotient",  32'(dif.quotient),  32'd0);
        chk("rst_remainder", 32'(dif.remainder), 32'd0);
        chk("rst_div_zero",  32'(dif.div_zero),  32'd0);
        chk("rst_overflow",  32'(dif.overflow),  32'd0);
        #150;
        rst_n = 1'b1;

        // Single operation: exactly one pulse, 10 edges later.
        drive_vec(tbl[0]);
        idle(14);

        // Directed table streamed back-to-back.
        for (int i = 0; i < 12; i++) drive_vec(tbl[i]);
        idle(14);

        // Randomised traffic with occasional bubbles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            drive_rand();
        end
        idle(14);

        // Reset while five operations are in flight: none of them may emerge.
        for (int i = 0; i < 5; i++) drive_rand();
        idle(1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        rst_n = 1'b1;
        idle(15);

        // Fresh operation after release.
        drive_vec(tbl[4]);
        idle(14);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_restoring_divider.md
# pipeline_restoring_divider

Fully pipelined signed divider: 16-bit dividend by 8-bit divisor, giving an 8-bit signed quotient and an 8-bit signed remainder. It is the inverse of `pipeline_booth_multiplier`: feeding that block's `product` and `b` back in here recovers `a`. It accepts one operation per clock, carries a valid tag through the pipeline, and is used as the self-check and inverse datapath next to the multiplier in the arithmetic test chain.

## Interface
- No parameters. Widths are fixed to match the 8x8->16 multiplier.
- `clk` input 1: single clock, all registers on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands are sampled on the rising edge where this is high.
- `dividend` input 16: signed, two's complement.
- `divisor` input 8: signed, two's complement.
- `out_valid` output 1: result on the outputs is valid this cycle.
- `quotient` output 8: signed, truncated toward zero, saturated on overflow.
- `remainder` output 8: signed, carries the sign of the dividend.
- `div_zero` output 1: divisor was 0 for this result.
- `overflow` output 1: true quotient lies outside [-128, 127].

## Operation
- Stage 1 (input register):
  - latch `in_valid`.
  - latch the sign of the dividend and the quotient sign `qs = dividend[15] ^ divisor[7]`.
  - latch the zero-divisor flag.
  - latch unsigned magnitudes: `|dividend|` in 16 bits (so -32768 gives 0x8000) and `|divisor|` in 8 bits (so -128 gives 0x80).
- Stages 2-9: unsigned restoring division, 2 quotient bits per stage, MSB first, 16 iterations in total.
  - Partial remainder is 9 bits wide (one guard bit).
  - Each iteration: shift in the next dividend bit; trial-subtract `|divisor|`; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore and set it to 0.
- Stage 10 (sign fix and output register):
  - Unsigned quotient `Qu` is 16 bits; unsigned remainder `Ru` is at most 127.
  - Signed quotient is `qs ? -Qu : Qu`.
  - `overflow` = (`qs`=0 and `Qu` > 127) or (`qs`=1 and `Qu` > 128).
  - On overflow, `quotient` is 8'h7F if `qs`=0, else 8'h80.
  - `remainder` = dividend sign ? `-Ru` : `Ru`. It always fits in 8 bits and is exact even when the quotient overflows.
  - Divide by zero forces `quotient`=8'h00, `remainder`=8'h00, `div_zero`=1, `overflow`=0. The pipeline still advances normally.
- When `in_valid` is low, a bubble propagates: `out_valid`=0 exactly 10 cycles later.
  - Data registers may hold don't-care values during a bubble.
  - Flags `div_zero` and `overflow` are forced to 0 whenever `out_valid`=0.
- There is no stall or backpressure; the pipeline advances every clock.

## Timing
- Latency: operands sampled at edge N produce a result at edge N+10, so outputs are valid during the cycle after that edge.
- Throughput: one operation per cycle. Back-to-back `in_valid` gives back-to-back `out_valid` in the same order.
- Reset:
  - The asynchronous assertion of `rst_n` clears every valid bit immediately.
  - `out_valid`, `quotient`, `remainder`, `div_zero` and `overflow` all reset to 0.
  - Data-path registers reset to 0.
- Reset mid-operation discards all in-flight operations. No stale `out_valid` appears after release.
- First sample after release: the first rising edge with `rst_n`=1 and `in_valid`=1.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 for 250 ns with a 50 ns clock.
  - Required: all outputs 0.
  - Then assert `in_valid` once. Required: exactly one `out_valid` pulse, 10 cycles later.
- Multiplier inverse:
  - 20/4 -> q=5, r=0.
  - -63 (16'hFFC1) / 7 -> q=8'hF7 (-9), r=0.
  - Streamed back-to-back: results appear on consecutive cycles, in order.
- Sign rules:
  - 23/-5 -> q=-4 (8'hFC), r=3.
  - -23/5 -> q=-4, r=-3 (8'hFD).
  - -23/-5 -> q=4, r=-3.
- Divide by zero:
  - 1234/0 -> `div_zero`=1, q=0, r=0, `overflow`=0.
  - The following valid operation 100/10 -> q=10 with `div_zero`=0.
- Overflow and edges:
  - 1000/2 -> q=8'h7F, `overflow`=1, r=0.
  - -32768/-1 -> q=8'h7F, `overflow`=1, r=0.
  - -128/1 -> q=8'h80, `overflow`=0.
  - -32768/-128 -> q=8'h7F, `overflow`=1, r=0.
  - 127/-128 -> q=0, r=127.
- Reset mid-flight:
  - Issue 5 consecutive operations, then pulse `rst_n` low for 1 ns after the 3rd edge.
  - Required: no `out_valid` ever appears for those operations.
  - A fresh operation after release completes normally.
